alu_seq: RTL

- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Width is generic; outputs are registered; flags are N/Z/C/V.
- Adds the shift ops LSL/LSR, a MOVK insert at a selectable halfword, and an iterative shift-add multiply (MUL).
- Sits between register read and writeback in the multi-cycle datapath; the control FSM drives in_valid/out_ready.

---
 rtl/alu_seq_if.sv | 37 +++
 rtl/alu_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for the handshaked ALU.
//   Request  (master -> slave): in_valid, op, a, b, imm, hw
//   Request  (slave -> master): in_ready
//   Response (slave -> master): out_valid, result, flag_n/z/c/v, op_err
//   Response (master -> slave): out_ready
// The master is the datapath control FSM; the slave is alu_seq.
interface alu_seq_if #(
    parameter int WIDTH = 64,
    parameter int IMM_W = 16,
    parameter int HW_W  = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [IMM_W-1:0] imm;
    logic [HW_W-1:0]  hw;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             op_err;

    modport master (
        output in_valid, op, a, b, imm, hw, out_ready,
        input  in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v, op_err
    );

    modport slave (
        input  in_valid, op, a, b, imm, hw, out_ready,
        output in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v, op_err
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result and N/Z/C/V flags.
// Single-cycle ops (logic, add/sub, MOVK, shifts) complete on the accept
// edge; MUL is an iterative shift-add that takes WIDTH+1 cycles.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - alu_seq_if.slave: in_valid/in_ready request handshake carrying
//            op/a/b/imm/hw; out_valid/out_ready response handshake carrying
//            result, flags and op_err.
module alu_seq #(
    parameter int WIDTH = 64,
    parameter int IMM_W = 16,
    parameter int HW_W  = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int SH_W   = $clog2(WIDTH);
    localparam int NUM_HW = WIDTH / IMM_W;
    localparam int CNT_W  = $clog2(WIDTH);

    localparam logic [3:0] OP_AND   = 4'd1;
    localparam logic [3:0] OP_ORR   = 4'd2;
    localparam logic [3:0] OP_NOT   = 4'd3;
    localparam logic [3:0] OP_PASSA = 4'd4;
    localparam logic [3:0] OP_PASSB = 4'd5;
    localparam logic [3:0] OP_ADD   = 4'd6;
    localparam logic [3:0] OP_SUB   = 4'd7;
    localparam logic [3:0] OP_MOVK  = 4'd8;
    localparam logic [3:0] OP_LSL   = 4'd9;
    localparam logic [3:0] OP_LSR   = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_result;
    logic             r_n;
    logic             r_z;
    logic             r_c;
    logic             r_v;
    logic             r_err;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic             w_mul_last;
    logic [WIDTH-1:0] w_mul_step;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_movk;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;
    logic             w_alu_v;
    logic             w_alu_err;

    // Signed overflow on a+b: operands agree in sign, sum does not.
    function automatic logic add_ovf(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] s);
        return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Signed overflow on x-y: operands differ in sign, difference differs from x.
    function automatic logic sub_ovf(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] d);
        return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
    endfunction

    assign w_accept   = bus.in_valid && (r_state == S_IDLE);
    assign w_mul_last = (r_count == CNT_W'(WIDTH - 1));
    assign w_mul_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.flag_n    = r_n;
    assign bus.flag_z    = r_z;
    assign bus.flag_c    = r_c;
    assign bus.flag_v    = r_v;
    assign bus.op_err    = r_err;

    // Single-cycle ALU, evaluated straight from the request bus so the
    // result can be captured on the accept edge.
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        w_alu_err = 1'b0;
        w_add     = {1'b0, bus.a} + {1'b0, bus.b};
        w_sub     = {1'b0, bus.a} - {1'b0, bus.b};
        // An out-of-range halfword index matches no slot and leaves b intact.
        w_movk    = bus.b;
        for (int k = 0; k < NUM_HW; k++) begin
            if (int'(bus.hw) == k) begin
                w_movk[k*IMM_W +: IMM_W] = bus.imm;
            end
        end
        case (bus.op)
            OP_AND:   w_alu_res = bus.a & bus.b;
            OP_ORR:   w_alu_res = bus.a | bus.b;
            OP_NOT:   w_alu_res = ~bus.a;
            OP_PASSA: w_alu_res = bus.a;
            OP_PASSB: w_alu_res = bus.b;
            OP_ADD: begin
                w_alu_res = w_add[WIDTH-1:0];
                w_alu_c   = w_add[WIDTH];
                w_alu_v   = add_ovf(bus.a, bus.b, w_add[WIDTH-1:0]);
            end
            OP_SUB: begin
                w_alu_res = w_sub[WIDTH-1:0];
                // The extra bit is the borrow; carry means no borrow.
                w_alu_c   = ~w_sub[WIDTH];
                w_alu_v   = sub_ovf(bus.a, bus.b, w_sub[WIDTH-1:0]);
            end
            OP_MOVK:  w_alu_res = w_movk;
            OP_LSL:   w_alu_res = bus.a << bus.b[SH_W-1:0];
            OP_LSR:   w_alu_res = bus.a >> bus.b[SH_W-1:0];
            OP_MUL:   w_alu_res = '0;
            default:  w_alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (bus.op == OP_MUL) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (w_mul_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // --- stage boundary: result/flag and multiply registers ---
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_err    <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (bus.op == OP_MUL) begin
                            r_mcand  <= bus.a;
                            r_mplier <= bus.b;
                            r_acc    <= '0;
                            r_count  <= '0;
                        end else begin
                            r_result <= w_alu_res;
                            r_n      <= w_alu_res[WIDTH-1];
                            r_z      <= (w_alu_res == '0);
                            r_c      <= w_alu_c;
                            r_v      <= w_alu_v;
                            r_err    <= w_alu_err;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_mul_step;
                    r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_count  <= r_count + CNT_W'(1);
                    // The final partial-product add is folded into the
                    // write-back edge so the whole op spans WIDTH+1 edges.
                    if (w_mul_last) begin
                        r_result <= w_mul_step;
                        r_n      <= w_mul_step[WIDTH-1];
                        r_z      <= (w_mul_step == '0);
                        r_c      <= 1'b0;
                        r_v      <= 1'b0;
                        r_err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
